down_counter_prescaled: RTL and testbench
=========================================

Name: down_counter_prescaled

Overview:
- Loadable down-counter: counts from a loaded value toward zero at a prescaled tick rate, flags terminal count, optionally reloads.
- Counterpart to the team's free-running upcounter; serves as the countdown/timer element on the board.
- Single clock domain; the prescaler is an internal clock-enable, not a derived clock.

Parameters:
- WIDTH, 4, counter and load value width in bits.
- DIV_COUNT, 50000000, clk cycles per count tick; must be >= 1. Prescaler width is $clog2(DIV_COUNT), minimum 1.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; low pauses the prescaler and counter.
- load  input  1  one-cycle load strobe; captures load_val.
- load_val  input  WIDTH  start value, also stored as the reload value.
- auto_reload  input  1  1 = reload on expiry; 0 = stop at zero.
- counter  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse, one cycle wide (registered).
- running  output  1  high in state COUNTING.
- expired  output  1  high in state EXPIRED.

Behaviour:
- Reset is synchronous and active-high: rst sampled high on posedge clk sets state=IDLE, counter=0, reload_reg=0, div_cnt=0, tc=0. Consequently running=0 and expired=0. rst has priority over every other input.
- States:
  - IDLE: counter holds; entered only from reset.
  - COUNTING: prescaler and counter active.
  - EXPIRED: counter holds 0; leaves only on load or rst.
- running and expired are decoded directly from the state register.
- Load (any state, rst low):
  - At the next edge: counter=load_val, reload_reg=load_val, div_cnt=0, tc=0.
  - State becomes COUNTING if load_val!=0, else EXPIRED. A zero load never pulses tc.
- Prescaler:
  - Advances only in COUNTING with en=1 and load=0.
  - If div_cnt==DIV_COUNT-1: tick, and div_cnt returns to 0. Otherwise div_cnt+1.
  - With en=0, div_cnt and counter hold exactly.
- Tick handling:
  - counter>1: counter decrements by 1.
  - counter==1: counter becomes 0 and tc=1 for that one cycle.
    - If auto_reload=1 (sampled at that tick): state stays COUNTING; on the next tick counter loads reload_reg and no decrement occurs on that tick. The zero value is therefore visible for a full period.
    - If auto_reload=0: state becomes EXPIRED.
    - If auto_reload=1 and reload_reg==0: state becomes EXPIRED.
- Latency:
  - A load sampled at edge E0 gives counter=load_val after E0.
  - With en held high, the first decrement occurs at edge E(DIV_COUNT); subsequent decrements follow every DIV_COUNT cycles.
- tc is high for exactly one cycle per expiry and is 0 in every other cycle.
- Simultaneous events:
  - load and tick in the same cycle: load wins; no decrement, no tc.
  - load while en=0: load still takes effect.
- Arithmetic is unsigned WIDTH-bit. Underflow below 0 is impossible by construction.
- The counter never exceeds the last loaded value.

Optional Feature:
- Macro: DOWN_COUNTER_FAST_SIM_EN.
- Defined: the prescaler is removed; a tick occurs every cycle in COUNTING with en=1 and load=0, which is identical to DIV_COUNT=1. Used for short simulations.
- Undefined: the prescaler operates per DIV_COUNT as specified above.
- The port list is identical in both builds.

Test Plan (WIDTH=4, DIV_COUNT=4, macro undefined unless stated):
- Assert rst for 2 cycles with load=1 and load_val=9 -> counter=0, tc=0, running=0, expired=0. The load is ignored.
- Load 3, auto_reload=0, en=1 -> counter reads 3, 2, 1, 0 at 4-cycle spacing. tc=1 only in the cycle counter becomes 0. Then expired=1 and running=0, and counter holds 0 for 20 or more cycles.
- Load 2, auto_reload=1 -> sequence 2, 1, 0, 2, 1, 0 … at 4-cycle spacing. tc pulses once every 12 cycles with width 1.
- Load 5, then drop en for 5 cycles mid-period -> counter and prescaler freeze. The next decrement is delayed by exactly 5 cycles.
- Assert load with load_val=7 in the tick cycle while counter=1 -> counter=7 next cycle, no tc pulse, running=1.
- Load 0 -> expired=1 next cycle with no tc. Then load 4 and assert rst after 6 cycles -> all outputs at reset values next cycle.
- Rerun the second scenario with DOWN_COUNTER_FAST_SIM_EN defined -> counter reads 3, 2, 1, 0 on consecutive cycles.

Source files
------------

// File: rtl/down_counter_prescaled.sv
// down_counter_prescaled: loadable down-counter with prescaled ticks, terminal-count pulse and optional auto-reload; DOWN_COUNTER_FAST_SIM_EN makes every enabled cycle a tick
module down_counter_prescaled #(
  parameter int WIDTH = 4,
  parameter int DIV_COUNT = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             running,
  output logic             expired
);
  typedef enum logic [1:0] {IDLE, COUNTING, EXPIRED} state_t;
  state_t state;
  logic [WIDTH-1:0] reload_reg;
  logic adv;
  logic tick;
  assign adv = state == COUNTING && en && !load;
  assign running = state == COUNTING;
  assign expired = state == EXPIRED;
`ifdef DOWN_COUNTER_FAST_SIM_EN
  assign tick = adv;
`else
  localparam int PW = DIV_COUNT > 1 ? $clog2(DIV_COUNT) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV_COUNT - 1);
  logic [PW-1:0] div_cnt;
  assign tick = adv && div_cnt == DIV_LAST;
  always_ff @(posedge clk)
    if (rst || load) div_cnt <= '0;
    else if (adv) div_cnt <= tick ? '0 : div_cnt + PW'(1);
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      counter <= '0;
      reload_reg <= '0;
      tc <= 1'b0;
    end else if (load) begin
      state <= load_val != '0 ? COUNTING : EXPIRED;
      counter <= load_val;
      reload_reg <= load_val;
      tc <= 1'b0;
    end else begin
      tc <= tick && counter == WIDTH'(1);
      counter <= tick ? (counter == '0 ? reload_reg : counter - WIDTH'(1)) : counter;
      state <= tick && counter == WIDTH'(1) && (!auto_reload || reload_reg == '0) ? EXPIRED : state;
    end
endmodule

// File: tb/tb_down_counter_prescaled.sv
// tb_down_counter_prescaled: randomized self-checking bench against an elapsed-tick arithmetic model
module tb_down_counter_prescaled;
  localparam int WIDTH = 4;
`ifdef DOWN_COUNTER_FAST_SIM_EN
  localparam int P = 1;
`else
  localparam int P = 4;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic auto_reload = 1'b0;
  logic [WIDTH-1:0] counter;
  logic tc, running, expired;
  int n_checks = 0;
  int n_fail = 0;
  logic m_idle = 1'b1;
  int m_v = 0;
  int m_k = 0;
  logic m_adv = 1'b0;
  down_counter_prescaled #(.WIDTH(WIDTH), .DIV_COUNT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .auto_reload(auto_reload), .counter(counter), .tc(tc),
    .running(running), .expired(expired)
  );
  always #5 clk = ~clk;
  function automatic logic exp_run();
    return !m_idle && m_v != 0 && (auto_reload || m_k / P < m_v);
  endfunction
  function automatic logic [WIDTH+2:0] exp_vec();
    int t, c;
    logic r;
    t = m_k / P;
    r = exp_run();
    c = m_idle ? 0 : auto_reload ? m_v - t % (m_v + 1) : (t >= m_v ? 0 : m_v - t);
    return {WIDTH'(c), m_adv && (m_k % P == 0) && c == 0, r, !m_idle && !r};
  endfunction
  always @(posedge clk)
    if (rst) begin
      m_idle <= 1'b1;
      m_v <= 0;
      m_k <= 0;
      m_adv <= 1'b0;
    end else if (load) begin
      m_idle <= 1'b0;
      m_v <= int'(load_val);
      m_k <= 0;
      m_adv <= 1'b0;
    end else begin
      m_adv <= en && exp_run();
      if (en && exp_run()) m_k <= m_k + 1;
    end
  task automatic test_reset();
    rst = 1'b1; load = 1'b1; load_val = 4'd9; en = 1'b1; auto_reload = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({counter, tc, running, expired} !== '0) begin
        n_fail++;
        $display("FAIL reset: got cnt=%0d tc=%b run=%b exp=%b, want all 0", counter, tc, running, expired);
      end
    end
    rst = 1'b0; load = 1'b0;
  endtask
  task automatic test_expire();
    int pulses = 0;
    auto_reload = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd3;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (counter !== 4'd3) begin
      n_fail++;
      $display("FAIL expire_load: got cnt=%0d want 3", counter);
    end
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      pulses += int'(tc);
      n_checks++;
      if ({counter, tc, running, expired} !== exp_vec()) begin
        n_fail++;
        $display("FAIL expire: got %b want %b", {counter, tc, running, expired}, exp_vec());
      end
    end
    n_checks++;
    if (pulses != 1 || expired !== 1'b1 || running !== 1'b0 || counter !== '0) begin
      n_fail++;
      $display("FAIL expire_end: got pulses=%0d exp=%b run=%b cnt=%0d want 1/1/0/0", pulses, expired, running, counter);
    end
  endtask
  task automatic test_auto_reload();
    int pulses = 0;
    int last = -1;
    auto_reload = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd2;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({counter, tc, running, expired} !== exp_vec()) begin
        n_fail++;
        $display("FAIL auto_reload: got %b want %b", {counter, tc, running, expired}, exp_vec());
      end
      if (tc === 1'b1) begin
        pulses++;
        n_checks++;
        if (last >= 0 && i - last != 3 * P) begin
          n_fail++;
          $display("FAIL auto_spacing: got %0d want %0d", i - last, 3 * P);
        end
        last = i;
      end
    end
    n_checks++;
    if (pulses != (48 - 2 * P) / (3 * P) + 1) begin
      n_fail++;
      $display("FAIL auto_pulses: got %0d want %0d", pulses, (48 - 2 * P) / (3 * P) + 1);
    end
  endtask
  task automatic test_pause();
    auto_reload = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd5;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 41; i++) begin
      en = !(i >= 6 && i < 11);
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({counter, tc, running, expired} !== exp_vec()) begin
        n_fail++;
        $display("FAIL pause: cycle %0d got %b want %b", i, {counter, tc, running, expired}, exp_vec());
      end
    end
    en = 1'b1;
  endtask
  task automatic test_load_at_tick();
    logic found = 1'b0;
    auto_reload = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd2;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (counter === 4'd1 && m_k % P == P - 1) found = 1'b1;
      else begin
        @(posedge clk); @(negedge clk);
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL load_tick_wait: got no tick cycle with cnt=1 want one within 40 cycles");
    end
    load = 1'b1; load_val = 4'd7;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    n_checks++;
    if ({counter, tc, running, expired} !== {4'd7, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL load_tick: got cnt=%0d tc=%b run=%b exp=%b want 7/0/1/0", counter, tc, running, expired);
    end
  endtask
  task automatic test_zero_load();
    auto_reload = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({counter, tc, running, expired} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_load: got cnt=%0d tc=%b run=%b exp=%b want 0/0/0/1", counter, tc, running, expired);
    end
    load_val = 4'd4;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({counter, tc, running, expired} !== exp_vec()) begin
        n_fail++;
        $display("FAIL zero_then_4: got %b want %b", {counter, tc, running, expired}, exp_vec());
      end
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({counter, tc, running, expired} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got cnt=%0d tc=%b run=%b exp=%b want all 0", counter, tc, running, expired);
    end
  endtask
  task automatic test_random();
    repeat (600) begin
      rst = $urandom_range(99) == 0;
      load = $urandom_range(11) == 0;
      en = $urandom_range(3) != 0;
      if (load) begin
        load_val = WIDTH'($urandom);
        auto_reload = 1'($urandom);
      end
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({counter, tc, running, expired} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random: got %b want %b", {counter, tc, running, expired}, exp_vec());
      end
    end
    rst = 1'b0; load = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_expire();
    test_auto_reload();
    test_pause();
    test_load_at_tick();
    test_zero_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
